// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_fsm
//  Description : Multi-cycle sequencer for the RV32I-subset datapath with
//                memory-ready stalls, illegal-opcode and timeout traps.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_fsm #(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] Opcode,
    input  logic [3:0] Funct,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       Branch,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic [3:0] Operation,
    output logic [3:0] state,
    output logic       illegal,
    output logic       timeout
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_ALU_WB   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WB   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] c_OP_R   = 7'b0110011;
    localparam logic [6:0] c_OP_I   = 7'b0010011;
    localparam logic [6:0] c_OP_LW  = 7'b0000011;
    localparam logic [6:0] c_OP_SW  = 7'b0100011;
    localparam logic [6:0] c_OP_BEQ = 7'b1100011;

    localparam logic [3:0] c_ALU_AND = 4'b0000;
    localparam logic [3:0] c_ALU_OR  = 4'b0001;
    localparam logic [3:0] c_ALU_ADD = 4'b0010;
    localparam logic [3:0] c_ALU_SUB = 4'b0110;

    localparam logic [CNT_W-1:0] c_MAX_WAIT = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    state_t           r_state;
    logic [6:0]       r_op;
    logic [3:0]       r_funct;
    logic [CNT_W-1:0] r_cnt;
    logic             r_illegal;
    logic             r_timeout;
    state_t           w_dec_next;
    logic             w_expired;

    function automatic logic [3:0] f_rtype_op(input logic [3:0] funct);
        case (funct)
            4'b1000: return c_ALU_SUB;
            4'b0111: return c_ALU_AND;
            4'b0110: return c_ALU_OR;
            default: return c_ALU_ADD;
        endcase
    endfunction

    function automatic logic [3:0] f_itype_op(input logic [2:0] funct3);
        case (funct3)
            3'b111:  return c_ALU_AND;
            3'b110:  return c_ALU_OR;
            default: return c_ALU_ADD;
        endcase
    endfunction

    // Dispatch combines opcode and funct legality; anything unsupported traps.
    always_comb begin
        w_dec_next = S_TRAP;
        case (Opcode)
            c_OP_R:  if (Funct inside {4'b0000, 4'b1000, 4'b0111, 4'b0110}) w_dec_next = S_EXEC_R;
            c_OP_I:  if (Funct[2:0] inside {3'b000, 3'b111, 3'b110}) w_dec_next = S_EXEC_I;
            c_OP_LW,
            c_OP_SW: w_dec_next = S_MEM_ADDR;
            c_OP_BEQ: if (Funct[2:0] == 3'b000) w_dec_next = S_BRANCH;
            default: w_dec_next = S_TRAP;
        endcase
    end

    // Ready arriving in the same cycle as the limit still wins over the trap.
    assign w_expired = !mem_ready && (r_cnt == c_MAX_WAIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_FETCH;
            r_op      <= '0;
            r_funct   <= '0;
            r_cnt     <= '0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_cnt <= '0;
            case (r_state)
                S_FETCH, S_MEM_RD, S_MEM_WR: begin
                    if (mem_ready) begin
                        r_state <= (r_state == S_FETCH)  ? S_DECODE :
                                   (r_state == S_MEM_RD) ? S_MEM_WB : S_FETCH;
                    end else if (w_expired) begin
                        r_state   <= S_TRAP;
                        r_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                S_DECODE: begin
                    r_op    <= Opcode;
                    r_funct <= Funct;
                    r_state <= w_dec_next;
                    if (w_dec_next == S_TRAP) r_illegal <= 1'b1;
                end
                S_EXEC_R, S_EXEC_I:  r_state <= S_ALU_WB;
                S_ALU_WB, S_MEM_WB,
                S_BRANCH:            r_state <= S_FETCH;
                S_MEM_ADDR:          r_state <= (r_op == c_OP_LW) ? S_MEM_RD : S_MEM_WR;
                S_TRAP:              r_state <= S_TRAP;
                default:             r_state <= S_TRAP;
            endcase
        end
    end

    // Moore decode; FETCH handshake and beq PCWrite follow mem_ready/Zero directly.
    always_comb begin
        PCWrite   = 1'b0;
        IRWrite   = 1'b0;
        Branch    = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        MemtoReg  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        RegWrite  = 1'b0;
        Operation = c_ALU_ADD;
        case (r_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_EXEC_R: begin
                ALUSrcA   = 1'b1;
                Operation = f_rtype_op(r_funct);
            end
            S_EXEC_I: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                Operation = f_itype_op(r_funct[2:0]);
            end
            S_ALU_WB: begin
                RegWrite  = 1'b1;
                Operation = (r_op == c_OP_R) ? f_rtype_op(r_funct) : f_itype_op(r_funct[2:0]);
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEM_RD: MemRead = 1'b1;
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEM_WR: MemWrite = 1'b1;
            S_BRANCH: begin
                Branch    = 1'b1;
                ALUSrcA   = 1'b1;
                Operation = c_ALU_SUB;
                PCWrite   = Zero;
            end
            default: ;
        endcase
        if (!reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            Branch   = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            MemtoReg = 1'b0;
            RegWrite = 1'b0;
        end
    end

    assign state   = r_state;
    assign illegal = r_illegal;
    assign timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control_fsm
//  Description : Self-checking bench; expected per-cycle traces are built
//                from instruction-level rules and compared every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_multicycle_control_fsm;

    localparam int MAX_WAIT = 15;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    // enable bundle: {PCWrite, IRWrite, Branch, MemRead, MemWrite, MemtoReg, RegWrite}
    localparam logic [6:0] EN_PCW = 7'b1000000;
    localparam logic [6:0] EN_IRW = 7'b0100000;
    localparam logic [6:0] EN_BR  = 7'b0010000;
    localparam logic [6:0] EN_MR  = 7'b0001000;
    localparam logic [6:0] EN_MW  = 7'b0000100;
    localparam logic [6:0] EN_M2R = 7'b0000010;
    localparam logic [6:0] EN_RW  = 7'b0000001;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [6:0] Opcode = '0;
    logic [3:0] Funct = '0;
    logic Zero = 1'b0;
    logic mem_ready = 1'b0;
    logic PCWrite, IRWrite, Branch, MemRead, MemWrite, MemtoReg, ALUSrcA, RegWrite;
    logic [1:0] ALUSrcB;
    logic [3:0] Operation, state;
    logic illegal, timeout;

    multicycle_control_fsm #(.MAX_WAIT(MAX_WAIT), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite), .Branch(Branch),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .RegWrite(RegWrite), .Operation(Operation), .state(state),
        .illegal(illegal), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] st;
        logic [6:0] en;
        bit         chk_ab;
        bit         chk_op;
        logic       a;
        logic [1:0] b;
        logic [3:0] op;
        logic       ill;
        logic       to;
        logic       rdy;
        logic       zero;
        logic [6:0] opc;
        logic [3:0] fn;
    } step_t;

    step_t q[$];
    logic  m_ill = 1'b0;
    logic  m_to  = 1'b0;
    int    checks = 0;
    int    errors = 0;
    int    stepno = 0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s step %0d got %0h exp %0h", tag, stepno, got, exp);
        end
    endtask

    // Non-DECODE cycles get random opcode/funct/ready/zero: they must not matter.
    function automatic step_t mk(input logic [3:0] st, input logic [6:0] en);
        step_t s;
        s.st = st; s.en = en; s.chk_ab = 1'b0; s.chk_op = 1'b0;
        s.a = 1'b0; s.b = 2'b00; s.op = 4'b0010;
        s.ill = m_ill; s.to = m_to;
        s.rdy = 1'($urandom); s.zero = 1'($urandom);
        s.opc = 7'($urandom); s.fn = 4'($urandom);
        return s;
    endfunction

    task automatic push_trap();
        for (int k = 0; k < 3; k++) q.push_back(mk(4'd15, 7'b0));
    endtask

    task automatic plan_wait(input logic [3:0] st, input logic [6:0] en_w, input logic [6:0] en_d,
                             input int dly, input bit alu, output bit trapped);
        step_t s;
        trapped = 1'b0;
        for (int i = 0; i < dly && i <= MAX_WAIT; i++) begin
            s = mk(st, en_w); s.rdy = 1'b0;
            if (alu) begin s.chk_ab = 1; s.chk_op = 1; s.a = 0; s.b = 2'b01; s.op = 4'b0010; end
            q.push_back(s);
        end
        if (dly > MAX_WAIT) begin
            m_to = 1'b1; push_trap(); trapped = 1'b1;
        end else begin
            s = mk(st, en_d); s.rdy = 1'b1;
            if (alu) begin s.chk_ab = 1; s.chk_op = 1; s.a = 0; s.b = 2'b01; s.op = 4'b0010; end
            q.push_back(s);
        end
    endtask

    task automatic plan_instr(input logic [6:0] opc, input logic [3:0] fn, input logic zero,
                              input int fdly, input int mdly);
        step_t s; bit tr; bit legal; logic [3:0] op;
        plan_wait(4'd0, EN_MR, EN_MR | EN_IRW | EN_PCW, fdly, 1'b1, tr);
        if (tr) return;
        s = mk(4'd1, 7'b0); s.opc = opc; s.fn = fn; q.push_back(s);
        legal = 1'b1; op = 4'b0010;
        case (opc)
            OP_R: case (fn)
                4'b0000: op = 4'b0010;  4'b1000: op = 4'b0110;
                4'b0111: op = 4'b0000;  4'b0110: op = 4'b0001;
                default: legal = 1'b0;
            endcase
            OP_I: case (fn[2:0])
                3'b000: op = 4'b0010;  3'b111: op = 4'b0000;  3'b110: op = 4'b0001;
                default: legal = 1'b0;
            endcase
            OP_LW, OP_SW: legal = 1'b1;
            OP_BEQ: legal = (fn[2:0] == 3'b000);
            default: legal = 1'b0;
        endcase
        if (!legal) begin m_ill = 1'b1; push_trap(); return; end
        case (opc)
            OP_R, OP_I: begin
                s = mk((opc == OP_R) ? 4'd2 : 4'd3, 7'b0);
                s.chk_ab = 1; s.chk_op = 1; s.a = 1; s.b = (opc == OP_R) ? 2'b00 : 2'b10; s.op = op;
                q.push_back(s);
                s = mk(4'd4, EN_RW); s.chk_op = 1; s.op = op; q.push_back(s);
            end
            OP_LW, OP_SW: begin
                s = mk(4'd5, 7'b0); s.chk_ab = 1; s.chk_op = 1; s.a = 1; s.b = 2'b10; s.op = 4'b0010;
                q.push_back(s);
                if (opc == OP_LW) begin
                    plan_wait(4'd6, EN_MR, EN_MR, mdly, 1'b0, tr);
                    if (!tr) q.push_back(mk(4'd7, EN_RW | EN_M2R));
                end else begin
                    plan_wait(4'd8, EN_MW, EN_MW, mdly, 1'b0, tr);
                end
            end
            default: begin
                s = mk(4'd9, EN_BR | (zero ? EN_PCW : 7'b0)); s.zero = zero;
                s.chk_ab = 1; s.chk_op = 1; s.a = 1; s.b = 2'b00; s.op = 4'b0110;
                q.push_back(s);
            end
        endcase
    endtask

    // Entered and left at a falling edge; inputs change there, outputs sampled 1ns later.
    task automatic run(input int nmax);
        step_t s; int n = 0;
        while (q.size() > 0 && n < nmax) begin
            s = q.pop_front(); n++; stepno++;
            mem_ready = s.rdy; Zero = s.zero; Opcode = s.opc; Funct = s.fn;
            #1;
            chk("state", {4'b0, state}, {4'b0, s.st});
            chk("enables", {1'b0, PCWrite, IRWrite, Branch, MemRead, MemWrite, MemtoReg, RegWrite},
                {1'b0, s.en});
            chk("illegal", {7'b0, illegal}, {7'b0, s.ill});
            chk("timeout", {7'b0, timeout}, {7'b0, s.to});
            if (s.chk_ab) chk("alusrc", {5'b0, ALUSrcA, ALUSrcB}, {5'b0, s.a, s.b});
            if (s.chk_op) chk("operation", {4'b0, Operation}, {4'b0, s.op});
            @(negedge clk);
        end
        q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b0; mem_ready = 1'b1; Zero = 1'b1;
        #1;
        chk("rst_state", {4'b0, state}, 8'h00);
        chk("rst_enables", {1'b0, PCWrite, IRWrite, Branch, MemRead, MemWrite, MemtoReg, RegWrite}, 8'h00);
        chk("rst_flags", {6'b0, illegal, timeout}, 8'h00);
        m_ill = 1'b0; m_to = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [6:0] ops [5];
        ops[0] = OP_R; ops[1] = OP_I; ops[2] = OP_LW; ops[3] = OP_SW; ops[4] = OP_BEQ;
        @(negedge clk);
        do_reset();
        // R add / sub / or
        plan_instr(OP_R, 4'b0000, 1'b0, 0, 0); run(1000);
        plan_instr(OP_R, 4'b1000, 1'b0, 0, 0); run(1000);
        plan_instr(OP_R, 4'b0110, 1'b0, 0, 0); run(1000);
        // lw with three not-ready cycles in MEM_RD, then sw, addi with instr[30] set
        plan_instr(OP_LW, 4'b1010, 1'b0, 0, 3); run(1000);
        plan_instr(OP_SW, 4'b0101, 1'b0, 0, 0); run(1000);
        plan_instr(OP_I, 4'b1000, 1'b0, 0, 0); run(1000);
        // beq taken and not taken
        plan_instr(OP_BEQ, 4'b0000, 1'b1, 0, 0); run(1000);
        plan_instr(OP_BEQ, 4'b1000, 1'b0, 0, 0); run(1000);
        // illegal opcode, then illegal funct, each cleared by reset
        plan_instr(7'b1111111, 4'b0000, 1'b0, 0, 0); run(1000);
        do_reset();
        plan_instr(OP_R, 4'b0001, 1'b0, 0, 0); run(1000);
        do_reset();
        plan_instr(OP_BEQ, 4'b0001, 1'b0, 0, 0); run(1000);
        do_reset();
        // fetch timeout, then ready arriving exactly at the limit
        plan_instr(OP_R, 4'b0000, 1'b0, MAX_WAIT + 1, 0); run(1000);
        do_reset();
        plan_instr(OP_R, 4'b0111, 1'b0, MAX_WAIT, 0); run(1000);
        // store timeout and load ready at the limit
        plan_instr(OP_SW, 4'b0000, 1'b0, 0, MAX_WAIT + 1); run(1000);
        do_reset();
        plan_instr(OP_LW, 4'b0000, 1'b0, 0, MAX_WAIT); run(1000);
        // reset mid-instruction aborts; fresh fetch follows
        plan_instr(OP_LW, 4'b0000, 1'b0, 0, 5); run(4);
        do_reset();
        plan_instr(OP_I, 4'b0110, 1'b0, 1, 0); run(1000);
        // randomized instruction stream
        for (int i = 0; i < 300; i++) begin
            logic [6:0] opc;
            int fd, md;
            opc = ($urandom_range(0, 15) == 0) ? 7'($urandom) : ops[$urandom_range(0, 4)];
            fd = ($urandom_range(0, 19) == 0) ? $urandom_range(0, MAX_WAIT + 1) : $urandom_range(0, 2);
            md = ($urandom_range(0, 19) == 0) ? $urandom_range(0, MAX_WAIT + 1) : $urandom_range(0, 3);
            plan_instr(opc, 4'($urandom), 1'($urandom), fd, md);
            run(1000);
            if (m_ill || m_to) do_reset();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
